// File: rtl/resp_checker.sv
// Response checker: compares NSAMP dut_out samples, LAT cycles after start, against a 16-entry table.
// Optional tolerance compare is enabled by defining RESP_CHK_TOL_EN.
module resp_checker #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned NSAMP = 16,
    parameter int          TOL   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] dut_out,
    input  logic        start,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [18:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [3:0]  first_err,
    output logic        err_seen
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] CMP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] LAST_IDX  = 4'(NSAMP - 1);
    localparam logic [3:0] WAIT_LOAD = 4'(LAT - 1);

    logic [1:0]  state;
    logic [3:0]  idx;
    logic [3:0]  wait_cnt;
    logic [18:0] exp_tab [16];
    logic [18:0] cur_exp;
    logic        mismatch;

    assign cur_exp = exp_tab[idx];

`ifdef RESP_CHK_TOL_EN
    logic [19:0] diff;
    logic [19:0] abs_diff;

    always_comb begin
        diff     = {dut_out[18], dut_out} - {cur_exp[18], cur_exp};
        abs_diff = diff[19] ? (20'd0 - diff) : diff;
        mismatch = abs_diff > 20'(TOL);
    end
`else
    logic unused_tol;
    assign unused_tol = ^TOL;
    assign mismatch   = (dut_out != cur_exp);
`endif

    // Table writes are locked out while a run is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                exp_tab[i] <= '0;
            end
        end else if (wr_en && !busy) begin
            exp_tab[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            first_err <= '0;
            err_seen  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx       <= '0;
                        err_cnt   <= '0;
                        first_err <= '0;
                        err_seen  <= 1'b0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        if (LAT == 0) begin
                            state <= CMP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= CMP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                CMP: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 5'd1;
                        if (!err_seen) begin
                            first_err <= idx;
                            err_seen  <= 1'b1;
                        end
                    end
                    idx <= idx + 4'd1;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Fold in this cycle's compare, since err_cnt updates on the same edge.
                        pass  <= !mismatch && (err_cnt == 5'd0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resp_checker.sv
// Directed bench for resp_checker: default instance (LAT=1, NSAMP=16) and a LAT=0, NSAMP=4 instance.
module tb_resp_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] dut_out = '0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [18:0] wr_data = '0;

    logic        busy, done, pass, err_seen;
    logic [4:0]  err_cnt;
    logic [3:0]  first_err;
    logic        busy2, done2, pass2, err_seen2;
    logic [4:0]  err_cnt2;
    logic [3:0]  first_err2;

    logic [18:0] stim [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    resp_checker #(.LAT(1), .NSAMP(16), .TOL(1)) u_dut (
        .clk(clk), .rst(rst), .dut_out(dut_out), .start(start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err(first_err), .err_seen(err_seen)
    );

    resp_checker #(.LAT(0), .NSAMP(4), .TOL(1)) u_dut2 (
        .clk(clk), .rst(rst), .dut_out(dut_out), .start(start2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .first_err(first_err2), .err_seen(err_seen2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 16; i++) stim[i] = 19'(5 * (i + 1));
    endtask

    // One full LAT=1 run; optionally attempts a table write to addr 2 mid-run.
    task automatic run_main(input bit busy_wr);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_on", busy, 1);
        check("done_low", done, 0);
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            dut_out = stim[k];
            if (busy_wr && k == 5) begin
                wr_en = 1'b1; wr_addr = 4'd2; wr_data = 19'd99;
            end else begin
                wr_en = 1'b0;
            end
            if (k == 15) check("done_early", done, 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [4:0] ec, input logic [3:0] fe);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass"}, pass, (ec == 0) ? 1 : 0);
        check({tag, "_err_cnt"}, err_cnt, ec);
        check({tag, "_first_err"}, first_err, fe);
        check({tag, "_err_seen"}, err_seen, (ec != 0) ? 1 : 0);
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_cnt", err_cnt, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 19'(5 * (i + 1));
            @(negedge clk);
        end
        wr_en = 1'b0;

        // Clean run.
        set_ramp();
        run_main(1'b0);
        check_result("clean", 5'd0, 4'd0);
        @(negedge clk);
        check("done_hold", done, 1);
        check("pass_hold", pass, 1);

        // Two injected errors.
        set_ramp();
        stim[3] = 19'd21;
        stim[9] = -19'sd50;
        run_main(1'b0);
`ifdef RESP_CHK_TOL_EN
        check_result("two_err", 5'd1, 4'd9);
`else
        check_result("two_err", 5'd2, 4'd3);
`endif

        // Off by two fails in either build.
        set_ramp();
        stim[3] = 19'd22;
        run_main(1'b0);
        check_result("off2", 5'd1, 4'd3);

        // LAT=0, NSAMP=4 with start re-pulsed during CMP.
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0; dut_out = 19'd5;
        check("s2_busy", busy2, 1);
        @(negedge clk); start2 = 1'b1; dut_out = 19'd10;
        @(negedge clk); start2 = 1'b1; dut_out = 19'd15;
        @(negedge clk); start2 = 1'b0; dut_out = 19'd20;
        check("s2_done_early", done2, 0);
        @(negedge clk);
        check("s2_done", done2, 1);
        check("s2_pass", pass2, 1);
        check("s2_err_cnt", err_cnt2, 0);
        @(negedge clk);
        check("s2_no_restart", busy2, 0);
        check("s2_done_hold", done2, 1);

        // Write while busy must be dropped.
        set_ramp();
        run_main(1'b1);
        set_ramp();
        run_main(1'b0);
        check_result("busy_wr", 5'd0, 4'd0);

        // Reset during CMP at idx 6, after an error has been counted.
        set_ramp();
        stim[2] = 19'd0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            dut_out = stim[k];
            @(negedge clk);
        end
        check("pre_rst_err", err_cnt, 1);
        dut_out = stim[6];
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pass", pass, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        check("mid_rst_first_err", first_err, 0);
        check("mid_rst_err_seen", err_seen, 0);
        @(negedge clk); rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_idle", busy, 0);
        check("post_rst_no_done", done, 0);

        // Table cleared: zeros pass, ramp fails on every sample.
        for (int i = 0; i < 16; i++) stim[i] = '0;
        run_main(1'b0);
        check_result("zero_tab", 5'd0, 4'd0);
        set_ramp();
        run_main(1'b0);
        check_result("all_err", 5'd16, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
